// File: rtl/hs_rr_mux.sv
// N-channel valid/busy concentrator: per-channel FIFOs drained round-robin into one tagged output register.
// Accept-to-o_valid latency is one edge; i_busy holds the output register, and full FIFOs raise busy.
module hs_rr_mux #(
  parameter  int data_widght = 8,
  parameter  int N_CH        = 4,
  parameter  int DEPTH       = 2,
  localparam int CH_W        = $clog2(N_CH)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_CH-1:0]             i_valid,
  input  logic [N_CH*data_widght-1:0] i_data,
  output logic [N_CH-1:0]             busy,
  output logic                        o_valid,
  output logic [data_widght-1:0]      o_data,
  output logic [CH_W-1:0]             o_ch,
  input  logic                        i_busy,
  output logic [N_CH-1:0]             o_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [data_widght-1:0] r_mem [N_CH][DEPTH];
  logic [PW-1:0]          r_wr  [N_CH];
  logic [PW-1:0]          r_rd  [N_CH];
  logic [CW-1:0]          r_cnt [N_CH];
  logic [CH_W-1:0]        r_rr;

  logic [N_CH-1:0] w_full;
  logic [N_CH-1:0] w_ne;
  logic [N_CH-1:0] w_push;
  logic [N_CH-1:0] w_pop;
  logic            w_gnt_vld;
  logic [CH_W-1:0] w_gnt;
  logic            w_load;

  always_comb begin
    w_full = '0;
    w_ne   = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_full[k] = (r_cnt[k] == CW'(DEPTH));
      w_ne[k]   = (r_cnt[k] != '0);
    end
  end

  // Busy looks only at the registered count, so a same-cycle pop never frees a slot.
  assign busy   = w_full | {N_CH{i_rst}};
  assign w_push = i_valid & ~busy;

  // Scan downward so the last hit is the nearest non-empty channel at or above r_rr.
  always_comb begin
    int c;
    c         = 0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      c = (int'(r_rr) + i) % N_CH;
      if (w_ne[CH_W'(c)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = CH_W'(c);
      end
    end
  end

  assign w_load = w_gnt_vld & (~o_valid | ~i_busy);

  always_comb begin
    w_pop = '0;
    if (w_load) w_pop[w_gnt] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (w_push[k]) r_mem[k][r_wr[k]] <= i_data[k*data_widght +: data_widght];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N_CH; k++) begin
        r_wr[k]  <= '0;
        r_rd[k]  <= '0;
        r_cnt[k] <= '0;
      end
      r_rr    <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch    <= '0;
      o_drop  <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (w_push[k]) r_wr[k] <= r_wr[k] + PW'(1);
        if (w_pop[k])  r_rd[k] <= r_rd[k] + PW'(1);
        if (w_push[k] && !w_pop[k])      r_cnt[k] <= r_cnt[k] + CW'(1);
        else if (!w_push[k] && w_pop[k]) r_cnt[k] <= r_cnt[k] - CW'(1);
      end
      o_drop <= o_drop | (i_valid & busy);
      if (w_load) begin
        o_valid <= 1'b1;
        o_data  <= r_mem[w_gnt][r_rd[w_gnt]];
        o_ch    <= w_gnt;
        r_rr    <= (w_gnt == CH_W'(N_CH - 1)) ? '0 : w_gnt + CH_W'(1);
      end else if (!i_busy) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hs_rr_mux.sv
// Bench for hs_rr_mux: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_hs_rr_mux;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] valid;
  logic [N*W-1:0] data;
  logic [N-1:0] busy;
  logic         ov;
  logic [W-1:0] od;
  logic [1:0]   och;
  logic         ibusy;
  logic [N-1:0] drop;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per channel plus the output slot.
  logic [W-1:0] mq [N][$];
  logic         m_ov;
  logic [W-1:0] m_od;
  int           m_och;
  int           m_rr;
  logic [N-1:0] m_drop;

  hs_rr_mux #(.data_widght(W), .N_CH(N), .DEPTH(D)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .i_data  (data),
    .busy    (busy),
    .o_valid (ov),
    .o_data  (od),
    .o_ch    (och),
    .i_busy  (ibusy),
    .o_drop  (drop)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] mbusy();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = rst || (mq[k].size() == D);
    return r;
  endfunction

  task automatic model_edge();
    logic [N-1:0] acc;
    bit found;
    int g;
    acc = '0;
    found = 0;
    g = 0;
    if (rst) begin
      for (int k = 0; k < N; k++) mq[k].delete();
      m_ov = 0; m_od = '0; m_och = 0; m_rr = 0; m_drop = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        acc[k] = valid[k] && (mq[k].size() < D);
        if (valid[k] && mq[k].size() >= D) m_drop[k] = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_rr + i) % N;
        if (!found && mq[c].size() > 0) begin
          found = 1;
          g = c;
        end
      end
      if ((!m_ov || !ibusy) && found) begin
        m_ov  = 1'b1;
        m_od  = mq[g].pop_front();
        m_och = g;
        m_rr  = (g + 1) % N;
      end else if (m_ov && !ibusy) begin
        m_ov = 1'b0;
      end
      for (int k = 0; k < N; k++)
        if (acc[k]) mq[k].push_back(data[k*W +: W]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; valid = '0; ibusy = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; valid = '1; data = $urandom; ibusy = 0;
    tick();
    #1;
    n_tests++;
    if (busy !== 4'hF) begin n_fail++; $display("FAIL reset_busy: got %h want f", busy); end
    tick();
    rst = 0; valid = '0;
    #1;
    n_tests++;
    if (ov !== 1'b0 || drop !== 4'h0 || busy !== 4'h0) begin
      n_fail++; $display("FAIL reset_state: ov=%b drop=%h busy=%h want 0/0/0", ov, drop, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    valid = 4'b0100; data = '0; data[2*W +: W] = 8'hA5;
    tick();
    valid = '0;
    n_tests++;
    if (ov !== 1'b0) begin n_fail++; $display("FAIL single_e0: ov=%b want 0", ov); end
    tick();
    n_tests++;
    if (ov !== 1'b1 || od !== 8'hA5 || och !== 2'd2) begin
      n_fail++; $display("FAIL single_e1: ov=%b od=%h ch=%0d want 1/a5/2", ov, od, och);
    end
    tick();
    n_tests++;
    if (ov !== 1'b0 || drop !== 4'h0) begin
      n_fail++; $display("FAIL single_e2: ov=%b drop=%h want 0/0", ov, drop);
    end
  endtask

  task automatic test_rr_order();
    logic [W-1:0] base;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      base = (rep == 0) ? 8'h10 : 8'h20;
      valid = '1;
      for (int k = 0; k < N; k++) data[k*W +: W] = base + W'(k);
      tick();
      valid = '0;
      for (int i = 0; i < N; i++) begin
        tick();
        n_tests++;
        if (ov !== 1'b1 || och !== 2'(i) || od !== base + W'(i) || od !== m_od) begin
          n_fail++; $display("FAIL rr_order%0d_%0d: ov=%b ch=%0d od=%h want 1/%0d/%h", rep, i, ov, och, od, i, base + W'(i));
        end
      end
      tick();
      n_tests++;
      if (ov !== 1'b0) begin n_fail++; $display("FAIL rr_drain%0d: ov=%b want 0", rep, ov); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ibusy = 1;
    for (int i = 0; i < 4; i++) begin
      valid = 4'b0010; data = '0; data[W +: W] = W'(i + 1);
      #1;
      n_tests++;
      if (busy[1] !== (i == 3)) begin n_fail++; $display("FAIL bp_busy%0d: got %b want %b", i, busy[1], i == 3); end
      tick();
    end
    valid = '0;
    n_tests++;
    if (drop !== 4'b0010 || ov !== 1'b1 || od !== 8'h01 || och !== 2'd1) begin
      n_fail++; $display("FAIL bp_hold: drop=%h ov=%b od=%h ch=%0d want 2/1/01/1", drop, ov, od, och);
    end
    tick();
    n_tests++;
    if (od !== 8'h01 || ov !== 1'b1) begin n_fail++; $display("FAIL bp_stable: od=%h ov=%b want 01/1", od, ov); end
    ibusy = 0;
    for (int i = 2; i <= 3; i++) begin
      tick();
      n_tests++;
      if (ov !== 1'b1 || od !== W'(i)) begin n_fail++; $display("FAIL bp_out%0d: ov=%b od=%h want 1/%h", i, ov, od, W'(i)); end
    end
    tick();
    n_tests++;
    if (ov !== 1'b0) begin n_fail++; $display("FAIL bp_end: ov=%b want 0", ov); end
  endtask

  task automatic test_alternate();
    int exp_seq [4] = '{0, 3, 0, 3};
    do_reset();
    ibusy = 1;
    for (int i = 0; i < 2; i++) begin
      valid = 4'b1001; data = $urandom;
      tick();
    end
    valid = '0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (ov !== 1'b1 || och !== 2'(exp_seq[i]) || od !== m_od) begin
        n_fail++; $display("FAIL alt_%0d: ov=%b ch=%0d od=%h want 1/%0d/%h", i, ov, och, od, exp_seq[i], m_od);
      end
      ibusy = 0;
      tick();
    end
    n_tests++;
    if (ov !== 1'b0) begin n_fail++; $display("FAIL alt_end: ov=%b want 0", ov); end
  endtask

  task automatic test_full_pop();
    do_reset();
    ibusy = 1;
    for (int i = 0; i < 3; i++) begin
      valid = 4'b0010; data = '0; data[W +: W] = W'(8'h31 + i);
      tick();
    end
    n_tests++;
    if (busy !== 4'b0010) begin n_fail++; $display("FAIL fp_full: busy=%h want 2", busy); end
    ibusy = 0; valid = 4'b0010; data[W +: W] = 8'h99;
    tick();
    valid = '0;
    n_tests++;
    if (drop !== 4'b0010 || busy !== 4'b0000 || od !== 8'h32) begin
      n_fail++; $display("FAIL fp_pop: drop=%h busy=%h od=%h want 2/0/32", drop, busy, od);
    end
    tick();
    n_tests++;
    if (ov !== 1'b1 || od !== 8'h33) begin n_fail++; $display("FAIL fp_last: ov=%b od=%h want 1/33", ov, od); end
    tick();
    n_tests++;
    if (ov !== 1'b0) begin n_fail++; $display("FAIL fp_end: ov=%b od=%h want 0", ov, od); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ibusy = 1;
    for (int i = 0; i < 2; i++) begin
      valid = 4'b0011; data = $urandom;
      tick();
    end
    rst = 1; valid = '1; ibusy = 0;
    #1;
    n_tests++;
    if (busy !== 4'hF) begin n_fail++; $display("FAIL rm_busy: got %h want f", busy); end
    tick();
    rst = 0; valid = '0;
    #1;
    n_tests++;
    if (ov !== 1'b0 || drop !== 4'h0 || busy !== 4'h0) begin
      n_fail++; $display("FAIL rm_after: ov=%b drop=%h busy=%h want 0/0/0", ov, drop, busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (ov !== 1'b0) begin n_fail++; $display("FAIL rm_stale%0d: ov=%b od=%h want 0", i, ov, od); end
    end
    valid = 4'b1000; data = '0; data[3*W +: W] = 8'h5A;
    tick();
    valid = '0;
    tick();
    n_tests++;
    if (ov !== 1'b1 || od !== 8'h5A || och !== 2'd3) begin
      n_fail++; $display("FAIL rm_new: ov=%b od=%h ch=%0d want 1/5a/3", ov, od, och);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst   = ($urandom_range(0, 299) == 0);
      valid = N'($urandom);
      data  = $urandom;
      ibusy = ($urandom_range(0, 2) == 0);
      #1;
      n_tests++;
      if (busy !== mbusy()) begin n_fail++; $display("FAIL rnd_busy@%0d: got %h want %h", cyc, busy, mbusy()); end
      tick();
      n_tests++;
      if (ov !== m_ov || drop !== m_drop || (m_ov && (od !== m_od || och !== 2'(m_och)))) begin
        n_fail++;
        $display("FAIL rnd_out@%0d: ov=%b od=%h ch=%0d drop=%h want %b/%h/%0d/%h", cyc, ov, od, och, drop, m_ov, m_od, m_och, m_drop);
      end
    end
    rst = 0; valid = '0;
  endtask

  initial begin
    rst = 1; valid = '0; data = '0; ibusy = 0;
    m_ov = 0; m_od = '0; m_och = 0; m_rr = 0; m_drop = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_rr_order();
    test_backpressure();
    test_alternate();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
